option_ctrl: RTL and testbench

OPTION_CTRL -- requirements
Module: option_ctrl

---
 rtl/option_pkg.sv | 11 +
 rtl/key2letter.sv | 40 ++++
 rtl/option_ctrl.sv | 111 +++++++++++
 tb/tb_option_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/option_pkg.sv
// option_pkg: scan-code constants, FSM state enum and reset letter bindings shared by option_ctrl
package option_pkg;
  typedef enum logic [1:0] {NAV, EDIT, COMMIT} state_t;
  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_DOWN  = 9'h172;
  localparam logic [8:0] KEY_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_RIGHT = 9'h174;
  localparam logic [8:0] KEY_ENTER = 9'h05A;
  localparam logic [8:0] KEY_ESC   = 9'h076;
  localparam logic [3:0][4:0] RST_FIND = {5'd3, 5'd18, 5'd0, 5'd22};
endpackage

// File: rtl/key2letter.sv
// key2letter: combinational PS/2 set-2 scan code (bit 8 = E0) to {hit, letter index A=0..Z=25}
module key2letter (
  input  logic [8:0] code,
  output logic       hit,
  output logic [4:0] idx
);
  always_comb begin
    hit = 1'b1;
    idx = 5'd0;
    case (code)
      9'h01C: idx = 5'd0;
      9'h032: idx = 5'd1;
      9'h021: idx = 5'd2;
      9'h023: idx = 5'd3;
      9'h024: idx = 5'd4;
      9'h02B: idx = 5'd5;
      9'h034: idx = 5'd6;
      9'h033: idx = 5'd7;
      9'h043: idx = 5'd8;
      9'h03B: idx = 5'd9;
      9'h042: idx = 5'd10;
      9'h04B: idx = 5'd11;
      9'h03A: idx = 5'd12;
      9'h031: idx = 5'd13;
      9'h044: idx = 5'd14;
      9'h04D: idx = 5'd15;
      9'h015: idx = 5'd16;
      9'h02D: idx = 5'd17;
      9'h01B: idx = 5'd18;
      9'h02C: idx = 5'd19;
      9'h03C: idx = 5'd20;
      9'h02A: idx = 5'd21;
      9'h01D: idx = 5'd22;
      9'h022: idx = 5'd23;
      9'h035: idx = 5'd24;
      9'h01A: idx = 5'd25;
      default: hit = 1'b0;
    endcase
  end
endmodule

// File: rtl/option_ctrl.sv
// option_ctrl: keyboard options menu (volume row, WASD key-binding row with letter edit); ports clk_25MHz, rst (sync active-low), key_valid/key_code in; which, wasd, find_num_1..4, volume, edit_active, bind_done out; OPTION_CTRL_SWAP_EN swaps duplicate letters instead of rejecting them
module option_ctrl
  import option_pkg::*;
#(
  parameter int VOL_RESET = 8,
  parameter int VOL_MAX   = 15
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [8:0] key_code,
  output logic       which,
  output logic [3:0] wasd,
  output logic [4:0] find_num_1,
  output logic [4:0] find_num_2,
  output logic [4:0] find_num_3,
  output logic [4:0] find_num_4,
  output logic [3:0] volume,
  output logic       edit_active,
  output logic       bind_done
);
  localparam logic [3:0] VMAX = 4'(VOL_MAX);
  localparam logic [3:0] VRST = 4'(VOL_RESET);
  state_t state, state_n;
  logic which_n, edit_n, done_n, hit;
  logic [1:0] slot, slot_n, dup_slot;
  logic [3:0] vol_n;
  logic [4:0] letter, letter_n, idx;
  logic [3:0][4:0] find, find_n, swap, commit_find;
  key2letter u_k2l (.code(key_code), .hit(hit), .idx(idx));
  always_comb begin
    dup_slot = slot;
    for (int j = 0; j < 4; j++)
      if (2'(j) != slot && find[j] == letter) dup_slot = 2'(j);
    swap = find;
    swap[dup_slot] = find[slot];
    swap[slot] = letter;
  end
`ifdef OPTION_CTRL_SWAP_EN
  assign commit_find = swap;
`else
  assign commit_find = (dup_slot != slot) ? find : swap;
`endif
  always_comb begin
    state_n = state;
    which_n = which;
    slot_n = slot;
    vol_n = volume;
    find_n = find;
    letter_n = letter;
    edit_n = edit_active;
    done_n = 1'b0;
    case (state)
      NAV: if (key_valid) begin
        if (key_code == KEY_UP || key_code == KEY_DOWN) which_n = ~which;
        else if (which) begin
          if (key_code == KEY_LEFT) slot_n = slot - 2'd1;
          else if (key_code == KEY_RIGHT) slot_n = slot + 2'd1;
          else if (key_code == KEY_ENTER) begin
            state_n = EDIT;
            edit_n = 1'b1;
          end
        end else begin
          if (key_code == KEY_RIGHT) vol_n = (volume >= VMAX) ? VMAX : volume + 4'd1;
          else if (key_code == KEY_LEFT) vol_n = (volume == 4'd0) ? 4'd0 : volume - 4'd1;
        end
      end
      EDIT: if (key_valid) begin
        if (hit) begin
          letter_n = idx;
          state_n = COMMIT;
        end else if (key_code == KEY_ESC) begin
          state_n = NAV;
          edit_n = 1'b0;
        end
      end
      default: begin
        state_n = NAV;
        edit_n = 1'b0;
        done_n = 1'b1;
        find_n = commit_find;
      end
    endcase
  end
  always_ff @(posedge clk_25MHz) begin
    if (!rst) begin
      state <= NAV;
      which <= 1'b1;
      slot <= 2'd0;
      volume <= VRST;
      find <= RST_FIND;
      letter <= 5'd0;
      edit_active <= 1'b0;
      bind_done <= 1'b0;
    end else begin
      state <= state_n;
      which <= which_n;
      slot <= slot_n;
      volume <= vol_n;
      find <= find_n;
      letter <= letter_n;
      edit_active <= edit_n;
      bind_done <= done_n;
    end
  end
  assign wasd = {2'b00, slot};
  assign find_num_1 = find[0];
  assign find_num_2 = find[1];
  assign find_num_3 = find[2];
  assign find_num_4 = find[3];
endmodule

// File: tb/tb_option_ctrl.sv
// tb_option_ctrl: randomized and directed self-checking bench for option_ctrl against a behavioural menu model
module tb_option_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_valid = 1'b0;
  logic [8:0] key_code = 9'h000;
  logic which, edit_active, bind_done;
  logic [3:0] wasd, volume;
  logic [4:0] find_num_1, find_num_2, find_num_3, find_num_4;
  int checks = 0;
  int errors = 0;
  bit m_which, m_edit, m_done, m_commit_due;
  int m_slot, m_vol, m_pend;
  int m_find[4];
  int codes[26] = '{'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B, 'h34, 'h33, 'h43, 'h3B, 'h42, 'h4B, 'h3A,
                    'h31, 'h44, 'h4D, 'h15, 'h2D, 'h1B, 'h2C, 'h3C, 'h2A, 'h1D, 'h22, 'h35, 'h1A};
  localparam int UP = 'h175, DN = 'h172, LT = 'h16B, RT = 'h174, ENT = 'h05A, ESC = 'h076;
  option_ctrl #(.VOL_RESET(8), .VOL_MAX(15)) dut (
    .clk_25MHz(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .which(which), .wasd(wasd), .find_num_1(find_num_1), .find_num_2(find_num_2),
    .find_num_3(find_num_3), .find_num_4(find_num_4), .volume(volume),
    .edit_active(edit_active), .bind_done(bind_done)
  );
  always #20 clk = ~clk;
  function automatic int letter_of(input int code);
    for (int i = 0; i < 26; i++) if (codes[i] == code) return i;
    return -1;
  endfunction
  task automatic model_reset();
    m_which = 1'b1; m_slot = 0; m_vol = 8; m_edit = 1'b0; m_done = 1'b0; m_commit_due = 1'b0;
    m_find[0] = 22; m_find[1] = 0; m_find[2] = 18; m_find[3] = 3;
  endtask
  task automatic model_step(input bit v, input int c, input bit r);
    int other;
    if (!r) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    if (m_commit_due) begin
      other = -1;
      for (int k = 0; k < 4; k++) if (k != m_slot && m_find[k] == m_pend) other = k;
      if (other < 0) m_find[m_slot] = m_pend;
`ifdef OPTION_CTRL_SWAP_EN
      else begin
        m_find[other] = m_find[m_slot];
        m_find[m_slot] = m_pend;
      end
`endif
      m_done = 1'b1;
      m_edit = 1'b0;
      m_commit_due = 1'b0;
    end else if (m_edit) begin
      if (v && letter_of(c) >= 0) begin
        m_pend = letter_of(c);
        m_commit_due = 1'b1;
      end else if (v && c == ESC) m_edit = 1'b0;
    end else if (v) begin
      if (c == UP || c == DN) m_which = !m_which;
      else if (m_which) begin
        if (c == LT) m_slot = (m_slot + 3) % 4;
        else if (c == RT) m_slot = (m_slot + 1) % 4;
        else if (c == ENT) m_edit = 1'b1;
      end else begin
        if (c == RT) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
        else if (c == LT) m_vol = (m_vol > 0) ? m_vol - 1 : 0;
      end
    end
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic compare_all();
    chk("which", int'(which), int'(m_which));
    chk("wasd", int'(wasd), m_slot);
    chk("volume", int'(volume), m_vol);
    chk("find_num_1", int'(find_num_1), m_find[0]);
    chk("find_num_2", int'(find_num_2), m_find[1]);
    chk("find_num_3", int'(find_num_3), m_find[2]);
    chk("find_num_4", int'(find_num_4), m_find[3]);
    chk("edit_active", int'(edit_active), int'(m_edit));
    chk("bind_done", int'(bind_done), int'(m_done));
  endtask
  task automatic tick(input bit v, input int c, input bit r = 1'b1);
    key_valid = v;
    key_code = 9'(c);
    rst = r;
    @(posedge clk);
    model_step(v, c, r);
    @(negedge clk);
    compare_all();
  endtask
  task automatic do_reset();
    tick(1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b0);
  endtask
  task automatic key(input int c);
    tick(1'b1, c);
  endtask
  int pool[12] = '{UP, DN, LT, RT, ENT, ESC, 'h1C, 'h1D, 'h1B, 'h23, 'h15, 'h24};
  initial begin
    int exp_w[5] = '{1, 2, 3, 0, 1};
    int c;
    @(negedge clk);
    do_reset();
    repeat (5) tick(1'b0, 0);
    chk("lit_which_rst", int'(which), 1);
    chk("lit_wasd_rst", int'(wasd), 0);
    chk("lit_f1_rst", int'(find_num_1), 22);
    chk("lit_f2_rst", int'(find_num_2), 0);
    chk("lit_f3_rst", int'(find_num_3), 18);
    chk("lit_f4_rst", int'(find_num_4), 3);
    chk("lit_vol_rst", int'(volume), 8);
    for (int i = 0; i < 5; i++) begin
      key(RT);
      chk("lit_wasd_walk", int'(wasd), exp_w[i]);
    end
    key(DN);
    chk("lit_which_down", int'(which), 0);
    repeat (10) key(RT);
    chk("lit_vol_max", int'(volume), 15);
    repeat (16) key(LT);
    chk("lit_vol_min", int'(volume), 0);
    do_reset();
    key(RT);
    key(ENT);
    chk("lit_edit_on", int'(edit_active), 1);
    key('h15);
    chk("lit_done_early", int'(bind_done), 0);
    tick(1'b0, 0);
    chk("lit_f2_q", int'(find_num_2), 16);
    chk("lit_done_pulse", int'(bind_done), 1);
    chk("lit_edit_off", int'(edit_active), 0);
    tick(1'b0, 0);
    chk("lit_done_end", int'(bind_done), 0);
    do_reset();
    key(ENT);
    key('h1C);
    tick(1'b0, 0);
`ifdef OPTION_CTRL_SWAP_EN
    chk("lit_swap_f1", int'(find_num_1), 0);
    chk("lit_swap_f2", int'(find_num_2), 22);
`else
    chk("lit_dup_f1", int'(find_num_1), 22);
    chk("lit_dup_f2", int'(find_num_2), 0);
`endif
    chk("lit_dup_done", int'(bind_done), 1);
    do_reset();
    key(ENT);
    key(ESC);
    key(UP);
    chk("lit_esc_f1", int'(find_num_1), 22);
    chk("lit_esc_edit", int'(edit_active), 0);
    chk("lit_esc_which", int'(which), 0);
    do_reset();
    key(RT);
    key(ENT);
    key('h15);
    key('h24);
    tick(1'b0, 0);
    chk("lit_drop_f2", int'(find_num_2), 16);
    chk("lit_drop_edit", int'(edit_active), 0);
    key(DN);
    key(RT);
    key(UP);
    key(RT);
    key(ENT);
    chk("lit_pre_rst_vol", int'(volume), 9);
    tick(1'b1, 'h1D, 1'b0);
    chk("lit_rst_edit_edit", int'(edit_active), 0);
    chk("lit_rst_edit_wasd", int'(wasd), 0);
    chk("lit_rst_edit_vol", int'(volume), 8);
    chk("lit_rst_edit_f1", int'(find_num_1), 22);
    tick(1'b0, 0);
    chk("lit_rst_edit_done", int'(bind_done), 0);
    for (int i = 0; i < 4000; i++) begin
      c = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 511)) : pool[$urandom_range(0, 11)];
      tick($urandom_range(0, 9) < 6, c, $urandom_range(0, 199) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
